// File: rtl/crypto_exec_sequencer_pkg.sv
// ============================================================================
// crypto_pkg
// Shared definitions for the 16-bit crypto execute path: opcode encodings
// (also used by the instruction decoder) and the sequencer state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package crypto_pkg;

  localparam logic [2:0] OP_XOR  = 3'b000;  // A ^ B
  localparam logic [2:0] OP_ADD  = 3'b001;  // A + B (mod 2^16)
  localparam logic [2:0] OP_SUB  = 3'b010;  // A - B (mod 2^16)
  localparam logic [2:0] OP_ROTL = 3'b011;  // A rotl imm
  localparam logic [2:0] OP_ROTR = 3'b100;  // A rotr imm
  localparam logic [2:0] OP_AND  = 3'b101;  // A & B
  localparam logic [2:0] OP_OR   = 3'b110;  // A | B
  localparam logic [2:0] OP_XROT = 3'b111;  // A ^ (B rotl imm)

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_CAP_B = 3'd3,
    ST_WB    = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/crypto_exec_sequencer_alu16.sv
// ============================================================================
// crypto_alu16
// Purely combinational two-operand function unit for the crypto datapath.
// Ports:
//   i_a, i_b   operands A and B
//   i_imm      rotate amount (0..15)
//   i_opcode   operation select (see crypto_pkg OP_*)
//   o_y        result, modulo 2^DW, no flags
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module crypto_alu16
  import crypto_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [3:0]    i_imm,
  input  logic [2:0]    i_opcode,
  output logic [DW-1:0] o_y
);

  // Rotates are done on a doubled copy of the operand so a shift of zero
  // naturally passes the value through unchanged.
  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input logic [3:0] n);
    logic [2*DW-1:0] w;
    w = {v, v} << n;
    return w[2*DW-1:DW];
  endfunction

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] v, input logic [3:0] n);
    logic [2*DW-1:0] w;
    w = {v, v} >> n;
    return w[DW-1:0];
  endfunction

  always_comb begin
    o_y = '0;
    case (i_opcode)
      OP_XOR:  o_y = i_a ^ i_b;
      OP_ADD:  o_y = i_a + i_b;
      OP_SUB:  o_y = i_a - i_b;
      OP_ROTL: o_y = rotl(i_a, i_imm);
      OP_ROTR: o_y = rotr(i_a, i_imm);
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_XROT: o_y = i_a ^ rotl(i_b, i_imm);
      default: o_y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/crypto_exec_sequencer.sv
// ============================================================================
// crypto_exec_sequencer
// Single-issue execute sequencer: fetches two source registers through the
// bank's single synchronous read port, computes f(A, B, imm) and writes the
// result back through the bank's write port. One operation per 5 cycles.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request, accepted only when idle
//   opcode/src_a/src_b/dst/imm  operation fields, sampled on accept
//   address_1, reg_data_1 bank read address / read data (1-edge latency)
//   address, data         bank write address / data
//   read_write_reg_bank   0 = read, 1 = write (high only in WB)
//   busy                  high from the cycle after accept through WB
//   done                  one-cycle pulse after writeback
//   result                last written value
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module crypto_exec_sequencer
  import crypto_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    opcode,
  input  logic [AW-1:0] src_a,
  input  logic [AW-1:0] src_b,
  input  logic [AW-1:0] dst,
  input  logic [3:0]    imm,
  output logic [AW-1:0] address_1,
  input  logic [DW-1:0] reg_data_1,
  output logic [AW-1:0] address,
  output logic [DW-1:0] data,
  output logic          read_write_reg_bank,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
);

  state_t        r_state;
  logic [2:0]    r_opcode;
  logic [AW-1:0] r_src_b;
  logic [AW-1:0] r_dst;
  logic [3:0]    r_imm;
  logic [DW-1:0] r_op_a;
  logic [DW-1:0] r_result_q;
  logic [DW-1:0] w_alu_y;

  // B is consumed straight off the bank read port during CAP_B.
  crypto_alu16 #(.DW(DW)) u_alu (
    .i_a      (r_op_a),
    .i_b      (reg_data_1),
    .i_imm    (r_imm),
    .i_opcode (r_opcode),
    .o_y      (w_alu_y)
  );

  // All bank-facing outputs are registered; each is loaded on the edge that
  // enters the state in which it must be valid. The async reset clears the
  // write strobe immediately so an interrupted operation never writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= ST_IDLE;
      r_opcode            <= '0;
      r_src_b             <= '0;
      r_dst               <= '0;
      r_imm               <= '0;
      r_op_a              <= '0;
      r_result_q          <= '0;
      address_1           <= '0;
      address             <= '0;
      data                <= '0;
      read_write_reg_bank <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      result              <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_opcode  <= opcode;
            r_src_b   <= src_b;
            r_dst     <= dst;
            r_imm     <= imm;
            address_1 <= src_a;
            busy      <= 1'b1;
            r_state   <= ST_RD_A;
          end
        end
        ST_RD_A: begin
          address_1 <= r_src_b;
          r_state   <= ST_RD_B;
        end
        ST_RD_B: begin
          r_op_a  <= reg_data_1;
          r_state <= ST_CAP_B;
        end
        ST_CAP_B: begin
          r_result_q          <= w_alu_y;
          data                <= w_alu_y;
          address             <= r_dst;
          read_write_reg_bank <= 1'b1;
          r_state             <= ST_WB;
        end
        ST_WB: begin
          read_write_reg_bank <= 1'b0;
          busy                <= 1'b0;
          done                <= 1'b1;
          result              <= r_result_q;
          r_state             <= ST_IDLE;
        end
        default: begin
          read_write_reg_bank <= 1'b0;
          busy                <= 1'b0;
          r_state             <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
